// File: rtl/vector_alu_arbiter.sv
// vector_alu_arbiter: round-robin arbiter feeding one vector ALU from two requesters, with a single shared response channel.
// Define VALU_ARB_DIVZ_CHECK_EN to flag op 0x4 with any zero divisor lane as an error.
module vector_alu_arbiter #(
  parameter int VECTORSPERREG = 4,
  parameter int DATAWIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req0_valid,
  input  logic req1_valid,
  output logic req0_ready,
  output logic req1_ready,
  input  logic [3:0] req0_op,
  input  logic [3:0] req1_op,
  input  logic [VECTORSPERREG*DATAWIDTH-1:0] req0_a,
  input  logic [VECTORSPERREG*DATAWIDTH-1:0] req0_b,
  input  logic [VECTORSPERREG*DATAWIDTH-1:0] req1_a,
  input  logic [VECTORSPERREG*DATAWIDTH-1:0] req1_b,
  input  logic [1:0] req0_tag,
  input  logic [1:0] req1_tag,
  output logic [VECTORSPERREG*DATAWIDTH-1:0] alu_ra1,
  output logic [VECTORSPERREG*DATAWIDTH-1:0] alu_ra2,
  output logic [3:0] alu_ctrl,
  input  logic [VECTORSPERREG*DATAWIDTH-1:0] alu_result,
  output logic rsp_valid,
  input  logic rsp_ready,
  output logic rsp_id,
  output logic [1:0] rsp_tag,
  output logic [VECTORSPERREG*DATAWIDTH-1:0] rsp_data,
  output logic rsp_err
);
  localparam int W = VECTORSPERREG * DATAWIDTH;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t state, next;
  logic prio, gnt1, accept, legal, cap_err;
  logic [3:0] op_q, sel_op;
  logic [W-1:0] a_q, b_q;
  // prio names the requester that wins a tie; it flips only on accept
  always_comb begin
    gnt1 = req1_valid && (!req0_valid || prio);
    req0_ready = !rst && state == IDLE && req0_valid && !gnt1;
    req1_ready = !rst && state == IDLE && gnt1;
    accept = req0_ready || req1_ready;
    sel_op = gnt1 ? req1_op : req0_op;
    legal = sel_op < 4'h7;
    next = state == IDLE    ? (accept ? (legal ? ISSUE : RESP) : IDLE) :
           state == ISSUE   ? CAPTURE :
           state == CAPTURE ? RESP :
           (rsp_ready ? IDLE : RESP);
    rsp_valid = state == RESP;
    alu_ctrl = state == ISSUE ? op_q : 4'hf;
    alu_ra1 = state == ISSUE ? a_q : '0;
    alu_ra2 = state == ISSUE ? b_q : '0;
  end
`ifdef VALU_ARB_DIVZ_CHECK_EN
  always_comb begin
    cap_err = 1'b0;
    for (int i = 0; i < VECTORSPERREG; i++)
      cap_err = cap_err | (op_q == 4'h4 && b_q[i*DATAWIDTH +: DATAWIDTH] == '0);
  end
`else
  assign cap_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prio <= 1'b0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      rsp_id <= 1'b0;
      rsp_tag <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        prio <= !gnt1;
        op_q <= sel_op;
        a_q <= gnt1 ? req1_a : req0_a;
        b_q <= gnt1 ? req1_b : req0_b;
        rsp_id <= gnt1;
        rsp_tag <= gnt1 ? req1_tag : req0_tag;
        rsp_data <= '0;
        rsp_err <= !legal;
      end
      if (state == CAPTURE) begin
        rsp_data <= alu_result;
        rsp_err <= cap_err;
      end
    end
  end
endmodule

// File: tb/tb_vector_alu_arbiter.sv
// tb_vector_alu_arbiter: directed and random checks of the arbiter against a transaction-level reference model.
module tb_vector_alu_arbiter;
  localparam int V = 4;
  localparam int D = 16;
  localparam int W = V * D;
`ifdef VALU_ARB_DIVZ_CHECK_EN
  localparam bit DIVZ_EN = 1'b1;
`else
  localparam bit DIVZ_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [3:0] req0_op = 0, req1_op = 0, alu_ctrl;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [1:0] req0_tag = 0, req1_tag = 0, rsp_tag;
  logic [W-1:0] alu_ra1, alu_ra2, rsp_data;
  logic [W-1:0] alu_result = '0;
  logic rsp_valid, rsp_ready = 0, rsp_id, rsp_err;
  int compared = 0, errs = 0;
  bit last = 1'b1;
  bit w;
  vector_alu_arbiter #(.VECTORSPERREG(V), .DATAWIDTH(D)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_tag(req0_tag), .req1_tag(req1_tag),
    .alu_ra1(alu_ra1), .alu_ra2(alu_ra2), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    int x, y, z;
    r = '0;
    for (int i = 0; i < V; i++) begin
      x = int'($signed(a[i*D +: D]));
      y = int'($signed(b[i*D +: D]));
      case (op)
        4'h0: z = x + y;
        4'h1: z = x - y;
        4'h2: z = x & y;
        4'h3: z = x | y;
        4'h4: z = (y == 0) ? 0 : x / y;
        4'h5: z = x ^ y;
        4'h6: z = x * y;
        default: z = 0;
      endcase
      r[i*D +: D] = z[D-1:0];
    end
    return r;
  endfunction
  always @(posedge clk) alu_result <= alu_f(alu_ctrl, alu_ra1, alu_ra2);
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic bit any_zero(input logic [W-1:0] b);
    for (int i = 0; i < V; i++) if (b[i*D +: D] == '0) return 1'b1;
    return 1'b0;
  endfunction
  task automatic txn(input bit v0, input bit v1, input logic [3:0] o0, input logic [3:0] o1,
                     input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [W-1:0] a1, input logic [W-1:0] b1,
                     input logic [1:0] t0, input logic [1:0] t1, input int hold, output bit win);
    logic [3:0] op;
    logic [W-1:0] a, b, edata;
    logic [1:0] t;
    bit lg, eerr;
    int lat;
    rsp_ready = 0;
    req0_valid = v0; req1_valid = v1; req0_op = o0; req1_op = o1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1; req0_tag = t0; req1_tag = t1;
    #1;
    win = (v0 && v1) ? !last : v1;
    chk("ready0", req0_ready, v0 && !win);
    chk("ready1", req1_ready, v1 && win);
    last = win;
    op = win ? o1 : o0;
    a = win ? a1 : a0;
    b = win ? b1 : b0;
    t = win ? t1 : t0;
    lg = op <= 4'h6;
    eerr = !lg || (DIVZ_EN && op == 4'h4 && any_zero(b));
    edata = lg ? alu_f(op, a, b) : '0;
    lat = lg ? 3 : 1;
    @(posedge clk);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("alu_ctrl", alu_ctrl, (lg && k == 1) ? op : 4'hf);
      chk("alu_ra1", alu_ra1, (lg && k == 1) ? a : '0);
      chk("alu_ra2", alu_ra2, (lg && k == 1) ? b : '0);
      chk("busy_ready", {req0_ready, req1_ready}, 2'b00);
      chk("rsp_valid", rsp_valid, k == lat);
    end
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_ready", {req0_ready, req1_ready}, 2'b00);
      chk("rsp_id", rsp_id, win);
      chk("rsp_tag", rsp_tag, t);
      chk("rsp_data", rsp_data, edata);
      chk("rsp_err", rsp_err, eerr);
    end
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    @(negedge clk);
    chk("rsp_done", rsp_valid, 1'b0);
  endtask
  initial begin
    logic [W-1:0] ra, rb, rc, rd;
    repeat (2) @(negedge clk);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_ctrl", alu_ctrl, 4'hf);
    chk("rst_ra", {alu_ra1, alu_ra2}, '0);
    chk("rst_rsp", {rsp_id, rsp_tag, rsp_data, rsp_err}, '0);
    chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
    rst = 0;
    @(negedge clk);
    txn(1, 0, 4'h0, 4'h0, 64'h0004_0003_0002_0001, 64'h0028_001E_0014_000A, '0, '0, 2'd1, 2'd0, 0, w);
    chk("add_data", rsp_data, 64'h002C_0021_0016_000B);
    chk("add_id", rsp_id, 1'b0);
    txn(0, 1, 4'h0, 4'h9, '0, '0, 64'h1234, 64'h5678, 2'd0, 2'd2, 0, w);
    chk("ill_data", rsp_data, '0);
    chk("ill_err", rsp_err, 1'b1);
    chk("ill_tag", rsp_tag, 2'd2);
    for (int i = 0; i < 4; i++) begin
      txn(1, 1, 4'h1, 4'h1, 64'h0009_0008_0007_0006, 64'h0001_0001_0001_0001,
          64'h0005_0005_0005_0005, 64'h0002_0002_0002_0002, 2'd0, 2'd3, 0, w);
      chk("rr_id", rsp_id, i % 2);
    end
    txn(1, 0, 4'h4, 4'h0, 64'h0008_0006_0004_0002, 64'h0001_0001_0000_0002, '0, '0, 2'd1, 2'd0, 0, w);
    chk("divz_err", rsp_err, DIVZ_EN);
    chk("divz_lane1", rsp_data[D +: D], '0);
    txn(0, 1, 4'h0, 4'h5, '0, '0, 64'hAAAA_5555_F0F0_0F0F, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 2'd1, 5, w);
    req0_valid = 1; req1_valid = 0; req0_op = 4'h0;
    #1 chk("drop_ready", req0_ready, 1'b1);
    #2 req0_valid = 0;
    @(negedge clk);
    chk("drop_valid", rsp_valid, 1'b0);
    chk("drop_ctrl", alu_ctrl, 4'hf);
    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      rc = {$urandom, $urandom}; rd = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rb[D +: D] = '0;
      case ($urandom_range(0, 2))
        0: txn(1, 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ra, rb, rc, rd,
               2'($urandom), 2'($urandom), $urandom_range(0, 3), w);
        1: txn(0, 1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ra, rb, rc, rd,
               2'($urandom), 2'($urandom), $urandom_range(0, 3), w);
        default: txn(1, 1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ra, rb, rc, rd,
               2'($urandom), 2'($urandom), $urandom_range(0, 3), w);
      endcase
    end
    req0_valid = 0; req1_valid = 1; req1_op = 4'h0; req1_tag = 2'd3;
    req1_a = 64'h0001_0001_0001_0001; req1_b = 64'h0001_0001_0001_0001;
    @(posedge clk);
    #1 req1_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_ctrl", alu_ctrl, 4'hf);
    chk("mid_rst_rsp", {rsp_id, rsp_tag, rsp_data, rsp_err}, '0);
    chk("mid_rst_ready", {req0_ready, req1_ready}, 2'b00);
    @(negedge clk);
    rst = 0;
    last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", rsp_valid, 1'b0);
    end
    txn(1, 1, 4'h2, 4'h3, 64'hFFFF, 64'h00FF, 64'h1, 64'h2, 2'd1, 2'd2, 1, w);
    chk("post_rst_tie", rsp_id, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errs);
    $finish;
  end
endmodule
